// File: rtl/cpu_sequencer_if.sv
// Sequencer bus: run control, ROM fetch, ALU flags and
// datapath strobes between the sequencer and its datapath.
interface cpu_sequencer_if #(
  parameter int PC_WIDTH = 5
);
  logic                start;
  logic                pause_req;
  logic [15:0]         instr_in;
  logic                alu_n;
  logic                alu_z;
  logic                alu_v;
  logic                alu_c;
  logic [PC_WIDTH-1:0] rom_addr;
  logic [15:0]         ir;
  logic                rf_read_en;
  logic                rf_write_en;
  logic                alu_en;
  logic [3:0]          flags;
  logic [2:0]          state;
  logic                halted;
  logic [15:0]         retired;

  modport master (
    input  start, pause_req, instr_in,
    input  alu_n, alu_z, alu_v, alu_c,
    output rom_addr, ir, rf_read_en,
    output rf_write_en, alu_en, flags,
    output state, halted, retired
  );

  modport slave (
    output start, pause_req, instr_in,
    output alu_n, alu_z, alu_v, alu_c,
    input  rom_addr, ir, rf_read_en,
    input  rf_write_en, alu_en, flags,
    input  state, halted, retired
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer with
// conditional execution, branch, halt and retire count.
module cpu_sequencer #(
  parameter int PC_WIDTH = 5,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  cpu_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_RST =
    PC_WIDTH'(RESET_PC);

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [15:0]         ir_q;
  logic [3:0]          flags_q;
  logic [15:0]         retired_q;
  logic                halted_q;
  logic                rd_q;
  logic                wr_q;
  logic                alu_q;
  logic                pass_q;
  logic                cond_ok;
  logic [3:0]          op;
  logic                is_alu;

  assign op     = ir_q[13:10];
  assign is_alu = (op != 4'hE) && (op != 4'hF);

  // flags_q is {N,Z,V,C}
  always_comb begin
    cond_ok = 1'b0;
    unique case (ir_q[15:14])
      2'b00: cond_ok = 1'b1;
      2'b01: cond_ok = flags_q[2];
      2'b10: cond_ok = flags_q[3];
      2'b11: cond_ok = flags_q[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc_q      <= PC_RST;
      ir_q      <= '0;
      flags_q   <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      alu_q     <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      alu_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) state_q <= FETCH;
        end
        FETCH: begin
          ir_q    <= bus.instr_in;
          rd_q    <= 1'b1;
          state_q <= DECODE;
        end
        DECODE: begin
          pass_q  <= cond_ok;
          alu_q   <= cond_ok && is_alu;
          wr_q    <= cond_ok && is_alu;
          state_q <= EXEC;
        end
        EXEC: begin
          state_q <= bus.pause_req ? IDLE : FETCH;
          pc_q    <= pc_q + 1'b1;
          if (pass_q) begin
            if (retired_q != 16'hFFFF)
              retired_q <= retired_q + 16'd1;
            if (is_alu) begin
              flags_q <= {bus.alu_n, bus.alu_z,
                          bus.alu_v, bus.alu_c};
            end else if (op == 4'hE) begin
              pc_q <= ir_q[PC_WIDTH-1:0];
            end else begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end
          end
        end
        HALT: begin
          if (bus.start) begin
            state_q  <= FETCH;
            halted_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.ir          = ir_q;
  assign bus.rf_read_en  = rd_q;
  assign bus.rf_write_en = wr_q;
  assign bus.alu_en      = alu_q;
  assign bus.flags       = flags_q;
  assign bus.state       = state_q;
  assign bus.halted      = halted_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench: stimulus queues the expected EXEC view of
// each instruction; a negedge monitor pops and compares.
module tb_cpu_sequencer;
  localparam int PW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.PC_WIDTH(PW)) bus();

  cpu_sequencer #(
    .PC_WIDTH(PW),
    .RESET_PC(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [15:0] rom [32];
  assign bus.instr_in = rom[bus.rom_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string name,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  pc;
    logic [15:0] ir;
    logic        alu;
    logic        wr;
    logic [3:0]  fl;
    logic [15:0] ret;
  } exp_t;

  exp_t q[$];
  exp_t e;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.state == 3'd3) begin
        if (q.size() == 0) begin
          check("exec_unexpected", 32'(bus.rom_addr), 32'hFFFF);
        end else begin
          e = q.pop_front();
          check("exec_pc", 32'(bus.rom_addr), 32'(e.pc));
          check("exec_ir", 32'(bus.ir), 32'(e.ir));
          check("exec_alu_en", 32'(bus.alu_en), 32'(e.alu));
          check("exec_wr_en", 32'(bus.rf_write_en), 32'(e.wr));
          check("exec_rd_en", 32'(bus.rf_read_en), 0);
          check("exec_flags", 32'(bus.flags), 32'(e.fl));
          check("exec_retired", 32'(bus.retired), 32'(e.ret));
        end
      end else if (bus.state == 3'd2) begin
        check("dec_rd_en", 32'(bus.rf_read_en), 1);
        check("dec_alu_en", 32'(bus.alu_en), 0);
        check("dec_wr_en", 32'(bus.rf_write_en), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(logic [3:0] f);
    {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} = f;
  endtask

  task automatic push(logic [4:0] pc, logic [15:0] ir,
                      logic alu, logic wr,
                      logic [3:0] fl, logic [15:0] ret);
    exp_t x;
    x.pc = pc; x.ir = ir; x.alu = alu;
    x.wr = wr; x.fl = fl; x.ret = ret;
    q.push_back(x);
  endtask

  // Entered in FETCH; returns one cycle after the EXEC edge.
  task automatic run_instr(logic [3:0] af, bit pd, bit pe);
    check("at_fetch", 32'(bus.state), 1);
    set_alu(af);
    step();
    bus.pause_req = pd;
    step();
    bus.pause_req = pe;
    step();
    bus.pause_req = 1'b0;
  endtask

  task automatic check_post(string name, int pc,
                            int ret, int fl);
    check({name, "_pc"}, 32'(bus.rom_addr), 32'(pc));
    check({name, "_ret"}, 32'(bus.retired), 32'(ret));
    check({name, "_flags"}, 32'(bus.flags), 32'(fl));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start     = 1'b0;
    bus.pause_req = 1'b0;
    set_alu(4'b0000);
    for (int i = 0; i < 32; i++) rom[i] = 16'h3C00;
    rom[0]  = 16'h0000;
    rom[1]  = 16'h4000;
    rom[2]  = 16'h4000;
    rom[3]  = 16'h3805;
    rom[5]  = 16'h3812;
    rom[18] = 16'h381F;
    rom[31] = 16'h0123;

    #2 rst = 1'b0;
    #1;
    check("rst_state", 32'(bus.state), 0);
    check("rst_pc", 32'(bus.rom_addr), 0);
    check("rst_ir", 32'(bus.ir), 0);
    check("rst_flags", 32'(bus.flags), 0);
    check("rst_retired", 32'(bus.retired), 0);
    check("rst_halted", 32'(bus.halted), 0);
    check("rst_strobes",
          32'({bus.rf_read_en, bus.alu_en, bus.rf_write_en}), 0);
    step();
    step();
    rst = 1'b1;
    bus.pause_req = 1'b1;
    step(); step(); step();
    check("idle_hold", 32'(bus.state), 0);
    bus.pause_req = 1'b0;

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;

    push(0, 16'h0000, 1, 1, 4'h0, 0);
    run_instr(4'b0100, 0, 0);
    check("alu_next_state", 32'(bus.state), 1);
    check_post("alu", 1, 1, 4'h4);

    push(1, 16'h4000, 1, 1, 4'h4, 1);
    run_instr(4'b0000, 0, 0);
    check_post("z_pass", 2, 2, 4'h0);

    push(2, 16'h4000, 0, 0, 4'h0, 2);
    run_instr(4'b1111, 1, 0);
    check("pause_dec_cont", 32'(bus.state), 1);
    check_post("z_fail", 3, 2, 4'h0);

    push(3, 16'h3805, 0, 0, 4'h0, 2);
    run_instr(4'b1111, 0, 0);
    check_post("br5", 5, 3, 4'h0);

    push(5, 16'h3812, 0, 0, 4'h0, 3);
    run_instr(4'b1111, 0, 0);
    check("br12_state", 32'(bus.state), 1);
    check_post("br12", 5'h12, 4, 4'h0);

    push(18, 16'h381F, 0, 0, 4'h0, 4);
    run_instr(4'b0000, 0, 0);
    check_post("br31", 31, 5, 4'h0);

    push(31, 16'h0123, 1, 1, 4'h0, 5);
    run_instr(4'b1001, 0, 1);
    check("pause_exec_idle", 32'(bus.state), 0);
    check_post("wrap", 0, 6, 4'h9);
    step();
    check("idle_stay", 32'(bus.state), 0);

    rom[0] = 16'hBC00;
    rom[1] = 16'hC000;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;

    push(0, 16'hBC00, 0, 0, 4'h9, 6);
    run_instr(4'b0000, 0, 1);
    check("halt_state", 32'(bus.state), 4);
    check("halt_flag", 32'(bus.halted), 1);
    check_post("halt", 1, 7, 4'h9);
    step(); step();
    check("halt_hold", 32'(bus.state), 4);
    check("halt_strobes",
          32'({bus.rf_read_en, bus.alu_en, bus.rf_write_en}), 0);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("resume_state", 32'(bus.state), 1);
    check("resume_pc", 32'(bus.rom_addr), 1);
    check("resume_halted", 32'(bus.halted), 0);

    push(1, 16'hC000, 1, 1, 4'h9, 7);
    check("at_fetch_c", 32'(bus.state), 1);
    set_alu(4'b0000);
    step();
    step();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_state", 32'(bus.state), 0);
    check("mid_rst_pc", 32'(bus.rom_addr), 0);
    check("mid_rst_flags", 32'(bus.flags), 0);
    check("mid_rst_ir", 32'(bus.ir), 0);
    check("mid_rst_retired", 32'(bus.retired), 0);
    check("mid_rst_strobes",
          32'({bus.rf_read_en, bus.alu_en, bus.rf_write_en}), 0);
    step();
    rst = 1'b1;
    step(); step();
    check("post_rst_idle", 32'(bus.state), 0);
    check("post_rst_pc", 32'(bus.rom_addr), 0);
    check("queue_drained", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
